// File: rtl/sevenseg_pkg.sv
// Shared helpers for the seven-segment scan driver: index-width sizing,
// output polarity handling and the idle (inactive) drive levels.
package sevenseg_pkg;

  // Smallest width that can hold values 0..value-1
  function automatic int sevenseg_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

  localparam int DEFAULT_NUM_DIGITS = 4;
  localparam int IDX_WIDTH          = sevenseg_clog2(DEFAULT_NUM_DIGITS);

  // Pin level of an inactive anode/segment for each polarity choice
  localparam logic IDLE_LEVEL_ACTIVE_LOW  = 1'b1;
  localparam logic IDLE_LEVEL_ACTIVE_HIGH = 1'b0;

  function automatic logic idle_level(input bit active_low);
    return active_low ? IDLE_LEVEL_ACTIVE_LOW : IDLE_LEVEL_ACTIVE_HIGH;
  endfunction

  // Converts a logical "driven/lit" bit into the physical pin level
  function automatic logic apply_polarity(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Scan timing for the seven-segment driver: slot length counter, PWM
// counter inside each slot, the scanned digit index and end-of-frame flag.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int DIM_WIDTH    = 4,
  parameter int IDX_W        = sevenseg_clog2(NUM_DIGITS)
) (
  input  logic                    CLK,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] refresh_period,
  output logic [PERIOD_WIDTH-1:0] slot_cnt,
  output logic [DIM_WIDTH-1:0]    pwm_cnt,
  output logic [IDX_W-1:0]        index,
  output logic                    frame_end
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic tick;

  // Slot ends once the counter reaches the period; >= lets a shrinking period cut the slot short
  always_comb begin
    tick      = enable && (slot_cnt >= refresh_period);
    frame_end = tick && (index == LAST_IDX);
  end

  // Slot counter restarts every slot and is held at zero while scanning is disabled
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      slot_cnt <= '0;
    end else if (!enable || tick) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // PWM counter free-runs (wrapping) inside a slot so each slot starts a fresh PWM period
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt <= '0;
    end else if (!enable || tick) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Digit index steps once per slot and wraps after the last digit
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      index <= '0;
    end else if (!enable) begin
      index <= '0;
    end else if (tick) begin
      if (index == LAST_IDX) begin
        index <= '0;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver. Holds a shadow copy
// of the digit patterns that is only reloaded at frame boundaries, gates
// each digit with mask, dead time and PWM brightness, and registers the
// pins with configurable polarity.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_WIDTH        = 8,
  parameter int PERIOD_WIDTH     = 24,
  parameter int DIM_WIDTH        = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic                               ENABLE,
  input  logic [PERIOD_WIDTH-1:0]            REFRESH_PERIOD,
  input  logic [DIM_WIDTH-1:0]               BRIGHTNESS,
  input  logic [NUM_DIGITS-1:0]              DIGIT_MASK,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0]    SEGS_IN,
  input  logic                               UPDATE,
  output logic [NUM_DIGITS-1:0]              ANODES,
  output logic [SEG_WIDTH-1:0]               SEGMENTS,
  output logic [sevenseg_clog2(NUM_DIGITS)-1:0] DIGIT_IDX,
  output logic                               FRAME_DONE
);

  localparam int   IDX_W      = sevenseg_clog2(NUM_DIGITS);
  localparam logic ANODE_IDLE = idle_level(ANODE_ACTIVE_LOW);
  localparam logic SEG_IDLE   = idle_level(SEG_ACTIVE_LOW);

  logic [PERIOD_WIDTH-1:0]         slot_cnt;
  logic [DIM_WIDTH-1:0]            pwm_cnt;
  logic [IDX_W-1:0]                index;
  logic                            frame_end;
  logic [NUM_DIGITS*SEG_WIDTH-1:0] shadow;
  logic                            pending;
  logic                            digit_on;
  logic [SEG_WIDTH-1:0]            shadow_sel;
  logic [NUM_DIGITS-1:0]           anode_next;
  logic [SEG_WIDTH-1:0]            seg_next;

  sevenseg_slot_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .DIM_WIDTH    (DIM_WIDTH),
    .IDX_W        (IDX_W)
  ) u_slot_timer (
    .CLK            (CLK),
    .rstn           (RSTN),
    .enable         (ENABLE),
    .refresh_period (REFRESH_PERIOD),
    .slot_cnt       (slot_cnt),
    .pwm_cnt        (pwm_cnt),
    .index          (index),
    .frame_end      (frame_end)
  );

  // Shadow patterns change only at a frame boundary so a frame never mixes old and new digits
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (!ENABLE) begin
      if (UPDATE) begin
        shadow  <= SEGS_IN;
        pending <= 1'b0;
      end
    end else if (frame_end && (pending || UPDATE)) begin
      shadow  <= SEGS_IN;
      pending <= 1'b0;
    end else if (UPDATE) begin
      pending <= 1'b1;
    end
  end

  // Digit is lit only when enabled, unmasked, past the dead-time cycle and inside the PWM on-window
  always_comb begin
    digit_on   = ENABLE && DIGIT_MASK[index] && (slot_cnt != '0) &&
                 ((BRIGHTNESS == '1) || (pwm_cnt < BRIGHTNESS));
    shadow_sel = shadow[index*SEG_WIDTH +: SEG_WIDTH];
    anode_next = '0;
    seg_next   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_next[i] = apply_polarity(digit_on && (index == IDX_W'(i)), ANODE_ACTIVE_LOW);
    end
    for (int j = 0; j < SEG_WIDTH; j++) begin
      seg_next[j] = apply_polarity(digit_on && shadow_sel[j], SEG_ACTIVE_LOW);
    end
  end

  // Pin registers: one cycle behind the scan state, idle level out of reset
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ANODES     <= {NUM_DIGITS{ANODE_IDLE}};
      SEGMENTS   <= {SEG_WIDTH{SEG_IDLE}};
      FRAME_DONE <= 1'b0;
    end else begin
      ANODES     <= anode_next;
      SEGMENTS   <= seg_next;
      FRAME_DONE <= frame_end;
    end
  end

  assign DIGIT_IDX = index;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (default parameters).
// A cycle model pushes expected pin values into a queue each time stimulus
// is applied; they are popped and compared after the clock edge.
module tb_sevenseg_scan_driver;
  import sevenseg_pkg::*;

  logic                 CLK = 1'b0;
  logic                 RSTN;
  logic                 ENABLE;
  logic [23:0]          REFRESH_PERIOD;
  logic [3:0]           BRIGHTNESS;
  logic [3:0]           DIGIT_MASK;
  logic [31:0]          SEGS_IN;
  logic                 UPDATE;
  logic [3:0]           ANODES;
  logic [7:0]           SEGMENTS;
  logic [IDX_WIDTH-1:0] DIGIT_IDX;
  logic                 FRAME_DONE;

  always #5 CLK = ~CLK;

  sevenseg_scan_driver dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .ENABLE         (ENABLE),
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .BRIGHTNESS     (BRIGHTNESS),
    .DIGIT_MASK     (DIGIT_MASK),
    .SEGS_IN        (SEGS_IN),
    .UPDATE         (UPDATE),
    .ANODES         (ANODES),
    .SEGMENTS       (SEGMENTS),
    .DIGIT_IDX      (DIGIT_IDX),
    .FRAME_DONE     (FRAME_DONE)
  );

  typedef struct packed {
    logic [3:0] anodes;
    logic [7:0] segs;
    logic       frame_done;
    logic [1:0] idx;
  } expect_t;

  expect_t sb_q[$];

  int n_checks    = 0;
  int n_errors    = 0;
  int cycle_num   = 0;
  int last_fd     = -1;
  int fd_interval = 0;

  // Reference model state
  logic [23:0] m_slot;
  logic [3:0]  m_pwm;
  logic [1:0]  m_idx;
  logic        m_pending;
  logic [7:0]  m_shadow [4];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle_num);
    end
  endtask

  task automatic modelReset();
    m_slot    = '0;
    m_pwm     = '0;
    m_idx     = '0;
    m_pending = 1'b0;
    for (int d = 0; d < 4; d++) m_shadow[d] = 8'h00;
  endtask

  // Predict what the pins show after the coming clock edge, given current inputs
  task automatic modelEdge();
    logic    tick;
    logic    fend;
    logic    lit;
    expect_t e;
    tick = ENABLE && (m_slot >= REFRESH_PERIOD);
    fend = tick && (m_idx == 2'd3);
    lit  = ENABLE && DIGIT_MASK[m_idx] && (m_slot != 0) &&
           ((BRIGHTNESS == 4'hF) || (m_pwm < BRIGHTNESS));
    e.anodes     = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e.segs       = lit ? ~m_shadow[m_idx] : 8'hFF;
    e.frame_done = fend;
    if (!ENABLE) begin
      if (UPDATE) begin
        for (int d = 0; d < 4; d++) m_shadow[d] = SEGS_IN[d*8 +: 8];
        m_pending = 1'b0;
      end
    end else if (fend && (m_pending || UPDATE)) begin
      for (int d = 0; d < 4; d++) m_shadow[d] = SEGS_IN[d*8 +: 8];
      m_pending = 1'b0;
    end else if (UPDATE) begin
      m_pending = 1'b1;
    end
    if (!ENABLE) begin
      m_slot = '0;
      m_pwm  = '0;
      m_idx  = '0;
    end else if (tick) begin
      m_slot = '0;
      m_pwm  = '0;
      m_idx  = m_idx + 2'd1;
    end else begin
      m_slot = m_slot + 24'd1;
      m_pwm  = m_pwm + 4'd1;
    end
    e.idx = m_idx;
    sb_q.push_back(e);
  endtask

  // One clock: predict, clock, then compare the DUT pins against the oldest prediction
  task automatic applyStimulus();
    expect_t e;
    modelEdge();
    @(posedge CLK);
    #1;
    cycle_num++;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("anodes", {28'd0, ANODES}, {28'd0, e.anodes});
      checkOutput("segments", {24'd0, SEGMENTS}, {24'd0, e.segs});
      checkOutput("frame_done", {31'd0, FRAME_DONE}, {31'd0, e.frame_done});
      checkOutput("digit_idx", {30'd0, DIGIT_IDX}, {30'd0, e.idx});
    end
    if (FRAME_DONE) begin
      if (last_fd >= 0) fd_interval = cycle_num - last_fd;
      last_fd = cycle_num;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic restartScan();
    ENABLE = 1'b0;
    applyStimulus();
    ENABLE = 1'b1;
    last_fd     = -1;
    fd_interval = 0;
  endtask

  initial begin
    int active_cnt;
    int digit_active [4];

    RSTN           = 1'b0;
    ENABLE         = 1'b0;
    REFRESH_PERIOD = 24'd3;
    BRIGHTNESS     = 4'hF;
    DIGIT_MASK     = 4'hF;
    SEGS_IN        = 32'h0;
    UPDATE         = 1'b0;
    modelReset();

    // Reset state
    #12;
    checkOutput("reset_anodes", {28'd0, ANODES}, 32'hF);
    checkOutput("reset_segments", {24'd0, SEGMENTS}, 32'hFF);
    checkOutput("reset_frame_done", {31'd0, FRAME_DONE}, 32'd0);
    checkOutput("reset_digit_idx", {30'd0, DIGIT_IDX}, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    applyStimulus();

    // Basic scan with pattern load at the first frame boundary
    ENABLE  = 1'b1;
    SEGS_IN = 32'h8844_2211;
    UPDATE  = 1'b1;
    last_fd = -1;
    applyStimulus();
    UPDATE = 1'b0;
    runCycles(50);
    checkOutput("fd_interval_full", fd_interval, 32'd16);

    // PWM brightness 4 over a 16-cycle slot
    BRIGHTNESS     = 4'd4;
    REFRESH_PERIOD = 24'd15;
    restartScan();
    active_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus();
      if (ANODES != 4'hF) active_cnt++;
    end
    checkOutput("pwm4_active_cycles", active_cnt, 32'd12);

    // Brightness 0 keeps every digit dark
    BRIGHTNESS = 4'd0;
    active_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus();
      if (ANODES != 4'hF) active_cnt++;
    end
    checkOutput("pwm0_active_cycles", active_cnt, 32'd0);

    // Mid-slot period decrease, then masked digits 1 and 3
    BRIGHTNESS = 4'hF;
    runCycles(9);
    REFRESH_PERIOD = 24'd3;
    runCycles(3);
    DIGIT_MASK = 4'b0101;
    restartScan();
    for (int d = 0; d < 4; d++) digit_active[d] = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (i < 32) begin
        for (int d = 0; d < 4; d++) if (!ANODES[d]) digit_active[d]++;
      end
    end
    checkOutput("mask_digit0_active", digit_active[0], 32'd6);
    checkOutput("mask_digit1_active", digit_active[1], 32'd0);
    checkOutput("mask_digit2_active", digit_active[2], 32'd6);
    checkOutput("mask_digit3_active", digit_active[3], 32'd0);
    checkOutput("fd_interval_masked", fd_interval, 32'd16);

    // Tear-free update issued during digit 1; load uses the frame-end SEGS_IN
    DIGIT_MASK = 4'hF;
    for (int i = 0; i < 40 && DIGIT_IDX != 2'd1; i++) applyStimulus();
    SEGS_IN = 32'h1234_5678;
    UPDATE  = 1'b1;
    applyStimulus();
    UPDATE  = 1'b0;
    SEGS_IN = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && ANODES != 4'b1011; i++) applyStimulus();
    checkOutput("tear_digit2_anodes", {28'd0, ANODES}, 32'hB);
    checkOutput("tear_digit2_old", {24'd0, SEGMENTS}, 32'hBB);
    for (int i = 0; i < 40 && ANODES != 4'b0111; i++) applyStimulus();
    checkOutput("tear_digit3_old", {24'd0, SEGMENTS}, 32'h77);
    for (int i = 0; i < 40 && ANODES != 4'b1110; i++) applyStimulus();
    checkOutput("tear_digit0_new", {24'd0, SEGMENTS}, 32'h00);

    // ENABLE dropped during digit 2, immediate load while disabled, then restart
    for (int i = 0; i < 40 && DIGIT_IDX != 2'd2; i++) applyStimulus();
    applyStimulus();
    ENABLE = 1'b0;
    applyStimulus();
    checkOutput("disable_anodes", {28'd0, ANODES}, 32'hF);
    checkOutput("disable_segments", {24'd0, SEGMENTS}, 32'hFF);
    checkOutput("disable_digit_idx", {30'd0, DIGIT_IDX}, 32'd0);
    SEGS_IN = 32'hA5A5_A5A5;
    UPDATE  = 1'b1;
    applyStimulus();
    UPDATE  = 1'b0;
    SEGS_IN = 32'h0;
    ENABLE  = 1'b1;
    applyStimulus();
    checkOutput("reenable_digit_idx", {30'd0, DIGIT_IDX}, 32'd0);
    for (int i = 0; i < 40 && ANODES != 4'b1110; i++) applyStimulus();
    checkOutput("reenable_digit0_anodes", {28'd0, ANODES}, 32'hE);
    checkOutput("disabled_load_segments", {24'd0, SEGMENTS}, 32'h5A);
    runCycles(6);

    // Asynchronous reset in the middle of a slot
    #2;
    RSTN = 1'b0;
    #1;
    checkOutput("async_reset_anodes", {28'd0, ANODES}, 32'hF);
    checkOutput("async_reset_segments", {24'd0, SEGMENTS}, 32'hFF);
    checkOutput("async_reset_digit_idx", {30'd0, DIGIT_IDX}, 32'd0);
    sb_q.delete();
    modelReset();
    @(negedge CLK);
    RSTN = 1'b1;
    applyStimulus();
    for (int i = 0; i < 40 && ANODES != 4'b1110; i++) applyStimulus();
    checkOutput("post_reset_digit0_anodes", {28'd0, ANODES}, 32'hE);
    checkOutput("post_reset_shadow_clear", {24'd0, SEGMENTS}, 32'hFF);
    runCycles(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised multiplexed seven-segment scan driver, successor to the fixed 4-digit scan logic in the board top level. Drives N common-anode digits from CSR-supplied patterns. Adds programmable refresh period, PWM brightness, per-digit masking, inter-digit blanking, tear-free frame-synchronous pattern update and configurable output polarity. Sits between the CSR block (SEVENSEG registers) and the board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..16)
SEG_WIDTH, 8, segments per digit including the decimal point
PERIOD_WIDTH, 24, width of the slot-length counter
DIM_WIDTH, 4, brightness resolution in bits
ANODE_ACTIVE_LOW, 1, 1 = an active anode is driven 0
SEG_ACTIVE_LOW, 1, 1 = a lit segment is driven 0

Ports:
CLK  in  1  clock
RSTN  in  1  reset, asynchronous, active-low
ENABLE  in  1  scan enable; low blanks the display and holds the counters
REFRESH_PERIOD  in  PERIOD_WIDTH  slot length minus 1, in cycles
BRIGHTNESS  in  DIM_WIDTH  PWM on-level; 0 = off, all-ones = full on
DIGIT_MASK  in  NUM_DIGITS  1 = digit shown; 0 = slot kept but blanked
SEGS_IN  in  NUM_DIGITS*SEG_WIDTH  logical patterns (1 = lit); digit i at [i*SEG_WIDTH +: SEG_WIDTH]
UPDATE  in  1  single-cycle strobe requesting a pattern load
ANODES  out  NUM_DIGITS  anode drives, physical polarity
SEGMENTS  out  SEG_WIDTH  segment drives, physical polarity
DIGIT_IDX  out  clog2(NUM_DIGITS)  digit currently scanned
FRAME_DONE  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Reset (asynchronous, RSTN=0): slot counter, PWM counter and index = 0. Shadow patterns and update-pending = 0. ANODES and SEGMENTS = all-inactive (all ones for the active-low defaults). DIGIT_IDX = 0, FRAME_DONE = 0.
- Slot counter counts from 0. tick is asserted when slot_cnt >= REFRESH_PERIOD. Using >= makes a mid-slot decrease of REFRESH_PERIOD end the slot on the next cycle.
- On tick, slot_cnt returns to 0 and the index advances. It wraps from NUM_DIGITS-1 to 0. Slot length = REFRESH_PERIOD+1 cycles, so REFRESH_PERIOD=0 gives a 1-cycle slot.
- frame_end = tick AND index==NUM_DIGITS-1. FRAME_DONE is registered and pulses in the cycle after frame_end.
- PWM counter has DIM_WIDTH bits. It is cleared on tick and free-runs (wrapping) within the slot.
- Digit on-condition, all terms required:
  - ENABLE = 1;
  - DIGIT_MASK[index] = 1;
  - slot_cnt != 0 (one-cycle dead time at each slot start, anti-ghosting);
  - BRIGHTNESS all-ones, or pwm_cnt < BRIGHTNESS.
- When on: ANODES has one bit active, at index, and SEGMENTS = shadow[index]. When off: all anodes and segments inactive.
- Polarity is applied at the output registers. Latency is 1 cycle from internal state to pins.
- Pattern update:
  - UPDATE sets pending.
  - The shadow copies SEGS_IN in the frame_end cycle if pending, and pending clears.
  - If UPDATE coincides with frame_end, the SEGS_IN of that same cycle is loaded.
  - With ENABLE=0, UPDATE loads the shadow on the next edge, with no wait.
  - A second UPDATE while pending is absorbed. The load always takes the SEGS_IN of the frame_end cycle.
- ENABLE falling: counters and index forced to 0 and outputs blanked on the next edge. pending is retained.
- ENABLE rising: scan restarts at digit 0, slot_cnt 0.

Decomposition:
- Package sevenseg_pkg holds:
  - clog2 helper and the IDX_WIDTH constant;
  - polarity-apply function;
  - inactive-pattern constants.
- One sub-module, sevenseg_slot_timer: slot counter, PWM counter, index, tick/frame_end generation.
- Shadow registers, update control and output stage stay in the top.

Test Plan:
1. Reset, then ENABLE=1, defaults, REFRESH_PERIOD=3, BRIGHTNESS=F, mask=F, SEGS_IN=0x8844_2211, UPDATE at cycle 0 -> after the first frame:
   - ANODES cycles 1110, 1101, 1011, 0111, each low for 3 of every 4 cycles;
   - SEGMENTS = ~11, ~22, ~44, ~88;
   - FRAME_DONE pulses every 16 cycles.
2. BRIGHTNESS=4, REFRESH_PERIOD=15 -> each digit is active for slot cycles 1..3 and 16..?; more precisely, active where pwm_cnt<4 excluding cycle 0, i.e. cycles 1,2,3 -> 3 active cycles per 16-cycle slot. BRIGHTNESS=0 -> ANODES stay 1111.
3. DIGIT_MASK=0101 -> digits 1 and 3 are never active, but their slots still consume 4 cycles each, so the frame stays 16 cycles.
4. UPDATE to SEGS_IN=0xFFFF_FFFF mid-frame at digit 1 -> digits 2 and 3 still show old values. The new pattern appears from the next digit-0 slot, with no tearing.
5. ENABLE dropped at digit 2, then re-raised -> outputs are inactive within 1 cycle. DIGIT_IDX=0 and scan restarts at digit 0.
6. RSTN asserted mid-slot asynchronously -> outputs go inactive before the next clock edge. The shadow clears, so after re-enable with no UPDATE, SEGMENTS stay inactive.
